// File: rtl/pulse_emitter.sv
// Debounced pushbutton to one-cycle start pulse, with optional auto-repeat
// while the button is held and a wrapping 8-bit count of emitted pulses.
module pulse_emitter #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned REPEAT_EN       = 0,
  parameter int unsigned REPEAT_DELAY    = 50000000,
  parameter int unsigned REPEAT_PERIOD   = 10000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_raw,
  output logic       signal_start,
  output logic       held,
  output logic [7:0] press_count
);

  // Debounce counter only ever holds 1 .. DEBOUNCE_CYCLES-1.
  localparam int DEB_W = $clog2(DEBOUNCE_CYCLES);
  // Repeat counter only ever holds 0 .. REPEAT_DELAY.
  localparam int REP_W = $clog2(REPEAT_DELAY + 1);

  localparam logic [DEB_W-1:0] DEB_ONE    = DEB_W'(1);
  localparam logic [DEB_W-1:0] DEB_LAST   = DEB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [REP_W-1:0] REP_ONE    = REP_W'(1);
  localparam logic [REP_W-1:0] REP_LAST   = REP_W'(REPEAT_DELAY);
  // After a repeat pulse the counter is rewound so the next pulse lands
  // exactly REPEAT_PERIOD cycles later without the counter growing past
  // REPEAT_DELAY.
  localparam logic [REP_W-1:0] REP_RELOAD = REP_W'(REPEAT_DELAY - REPEAT_PERIOD);

  localparam logic [1:0] IDLE         = 2'd0;
  localparam logic [1:0] PRESS_WAIT   = 2'd1;
  localparam logic [1:0] PRESSED      = 2'd2;
  localparam logic [1:0] RELEASE_WAIT = 2'd3;

  logic             btn_meta;
  logic             btn_sync;
  logic [1:0]       state_q;
  logic [1:0]       state_d;
  logic [DEB_W-1:0] deb_q;
  logic [DEB_W-1:0] deb_d;
  logic [REP_W-1:0] rep_q;
  logic [REP_W-1:0] rep_d;
  logic [REP_W-1:0] rep_inc;
  logic             held_d;
  logic             fire;

  // Two-flop synchronizer; btn_raw is sampled nowhere else.
  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every flop
    // samples pre-edge values; blocking here would collapse the two stages.
    if (reset) begin
      btn_meta <= 1'b0;
      btn_sync <= 1'b0;
    end else begin
      btn_meta <= btn_raw;
      btn_sync <= btn_meta;
    end
  end

  // Next-state logic: debounce FSM plus auto-repeat timing.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    state_d = state_q;
    deb_d   = deb_q;
    rep_d   = rep_q;
    held_d  = held;
    fire    = 1'b0;
    rep_inc = rep_q + REP_ONE;
    case (state_q)
      IDLE: begin
        if (btn_sync) begin
          state_d = PRESS_WAIT;
          deb_d   = DEB_ONE;
        end
      end
      PRESS_WAIT: begin
        if (!btn_sync) begin
          state_d = IDLE;
        end else if (deb_q == DEB_LAST) begin
          state_d = PRESSED;
          held_d  = 1'b1;
          fire    = 1'b1;
          rep_d   = '0;
        end else begin
          deb_d = deb_q + DEB_ONE;
        end
      end
      PRESSED: begin
        if (!btn_sync) begin
          state_d = RELEASE_WAIT;
          deb_d   = DEB_ONE;
        end else if (REPEAT_EN != 0) begin
          if (rep_inc == REP_LAST) begin
            fire  = 1'b1;
            rep_d = REP_RELOAD;
          end else begin
            rep_d = rep_inc;
          end
        end
      end
      RELEASE_WAIT: begin
        // A high sample here is release bounce: return silently, keeping
        // the repeat counter frozen where it was.
        if (btn_sync) begin
          state_d = PRESSED;
        end else if (deb_q == DEB_LAST) begin
          state_d = IDLE;
          held_d  = 1'b0;
        end else begin
          deb_d = deb_q + DEB_ONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, counters and registered outputs; reset wins over any pending pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      deb_q        <= '0;
      rep_q        <= '0;
      held         <= 1'b0;
      signal_start <= 1'b0;
      press_count  <= 8'd0;
    end else begin
      state_q      <= state_d;
      deb_q        <= deb_d;
      rep_q        <= rep_d;
      held         <= held_d;
      signal_start <= fire;
      if (fire) begin
        press_count <= press_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_pulse_emitter.sv
// Bench for pulse_emitter: three instances share one button/reset stream
// (D=4 no repeat, D=4 with repeat 8/4, D=2 no repeat). A run-length model
// predicts every output each cycle; literal checks pin key timings.
module tb_pulse_emitter;

  localparam int RDL = 8;
  localparam int RPR = 4;
  localparam int DEB [3] = '{4, 4, 2};
  localparam int REN [3] = '{0, 1, 0};

  logic        clk = 1'b0;
  logic        reset;
  logic        btn;
  logic [2:0]  start_o;
  logic [2:0]  held_o;
  logic [23:0] cnt_o;

  int total = 0;
  int bad   = 0;
  int edge_n = 0;

  always #5 clk = ~clk;

  pulse_emitter #(.DEBOUNCE_CYCLES(4), .REPEAT_EN(0), .REPEAT_DELAY(RDL), .REPEAT_PERIOD(RPR)) u_a (
    .clk(clk), .reset(reset), .btn_raw(btn),
    .signal_start(start_o[0]), .held(held_o[0]), .press_count(cnt_o[7:0]));

  pulse_emitter #(.DEBOUNCE_CYCLES(4), .REPEAT_EN(1), .REPEAT_DELAY(RDL), .REPEAT_PERIOD(RPR)) u_b (
    .clk(clk), .reset(reset), .btn_raw(btn),
    .signal_start(start_o[1]), .held(held_o[1]), .press_count(cnt_o[15:8]));

  pulse_emitter #(.DEBOUNCE_CYCLES(2), .REPEAT_EN(0), .REPEAT_DELAY(RDL), .REPEAT_PERIOD(RPR)) u_c (
    .clk(clk), .reset(reset), .btn_raw(btn),
    .signal_start(start_o[2]), .held(held_o[2]), .press_count(cnt_o[23:16]));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  // Behavioural model: a press is accepted once the synchronized level has
  // differed from the debounced level for DEB consecutive samples; repeat
  // pulses fall at hold times DELAY + k*PERIOD, hold time counting only
  // samples taken while steadily pressed.
  logic       m_s1, m_s2;
  logic       m_lvl   [3];
  logic       m_start [3];
  int         m_run   [3];
  int         m_h     [3];
  logic [7:0] m_cnt   [3];

  always @(posedge clk) begin : model
    logic smp;
    logic fire;
    edge_n++;
    if (reset) begin
      m_s1 = 1'b0;
      m_s2 = 1'b0;
      for (int i = 0; i < 3; i++) begin
        m_lvl[i] = 1'b0; m_start[i] = 1'b0; m_run[i] = 0; m_h[i] = 0; m_cnt[i] = 8'd0;
      end
    end else begin
      smp  = m_s2;
      m_s2 = m_s1;
      m_s1 = btn;
      for (int i = 0; i < 3; i++) begin
        fire = 1'b0;
        if (!m_lvl[i]) begin
          if (smp) begin
            m_run[i]++;
            if (m_run[i] == DEB[i]) begin
              m_lvl[i] = 1'b1; m_run[i] = 0; m_h[i] = 0; fire = 1'b1;
            end
          end else begin
            m_run[i] = 0;
          end
        end else begin
          if (!smp) begin
            m_run[i]++;
            if (m_run[i] == DEB[i]) begin
              m_lvl[i] = 1'b0; m_run[i] = 0;
            end
          end else begin
            if (m_run[i] == 0 && REN[i] != 0) begin
              m_h[i]++;
              if (m_h[i] >= RDL && (m_h[i] - RDL) % RPR == 0) fire = 1'b1;
            end
            m_run[i] = 0;
          end
        end
        m_start[i] = fire;
        if (fire) m_cnt[i] = m_cnt[i] + 8'd1;
      end
    end
  end

  // Every-cycle comparison of all three instances against the model.
  logic [2:0] prev_start = 3'b000;
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      check($sformatf("start%0d", i), 32'(start_o[i]), 32'(m_start[i]));
      check($sformatf("held%0d", i), 32'(held_o[i]), 32'(m_lvl[i]));
      check($sformatf("count%0d", i), 32'(cnt_o[8*i +: 8]), 32'(m_cnt[i]));
      check($sformatf("back_to_back%0d", i), 32'(start_o[i] & prev_start[i]), 32'd0);
    end
    prev_start = start_o;
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  logic bounce_seq [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

  initial begin
    reset = 1'b1;
    btn   = 1'b0;
    cycles(3);
    reset = 1'b0;
    cycles(4);
    check("reset_start_a", 32'(start_o[0]), 32'd0);
    check("reset_held_a", 32'(held_o[0]), 32'd0);
    check("reset_count_a", 32'(cnt_o[7:0]), 32'd0);

    // Clean press held 20 cycles: pulse in the cycle after edge N+5.
    btn = 1'b1;
    cycles(5);
    check("clean_no_early_start", 32'(start_o[0]), 32'd0);
    check("clean_no_early_held", 32'(held_o[0]), 32'd0);
    cycles(1);
    check("clean_start", 32'(start_o[0]), 32'd1);
    check("clean_held_rise", 32'(held_o[0]), 32'd1);
    check("clean_repeat_dut_start", 32'(start_o[1]), 32'd1);
    cycles(1);
    check("clean_one_cycle", 32'(start_o[0]), 32'd0);
    cycles(13);
    btn = 1'b0;
    cycles(12);
    check("clean_held_fall", 32'(held_o[0]), 32'd0);
    check("clean_count_a", 32'(cnt_o[7:0]), 32'd1);
    check("clean_count_b", 32'(cnt_o[15:8]), 32'd4);
    check("clean_count_c", 32'(cnt_o[23:16]), 32'd1);

    // Short bounce burst: too short for D=4, long enough for D=2.
    foreach (bounce_seq[k]) begin
      btn = bounce_seq[k];
      cycles(1);
    end
    btn = 1'b0;
    cycles(10);
    check("bounce_held_a", 32'(held_o[0]), 32'd0);
    check("bounce_count_a", 32'(cnt_o[7:0]), 32'd1);
    check("bounce_count_b", 32'(cnt_o[15:8]), 32'd4);
    check("bounce_count_c", 32'(cnt_o[23:16]), 32'd2);

    // Release bounce 0,1,0 while pressed: held stays, no extra pulse.
    btn = 1'b1; cycles(8);
    btn = 1'b0; cycles(1);
    btn = 1'b1; cycles(1);
    btn = 1'b0; cycles(1);
    btn = 1'b1; cycles(4);
    check("rel_bounce_held_a", 32'(held_o[0]), 32'd1);
    check("rel_bounce_count_a", 32'(cnt_o[7:0]), 32'd2);
    check("rel_bounce_count_c", 32'(cnt_o[23:16]), 32'd3);
    btn = 1'b0;
    cycles(10);
    check("rel_bounce_released", 32'(held_o[0]), 32'd0);
    check("rel_bounce_count_b", 32'(cnt_o[15:8]), 32'd5);

    // Auto-repeat, held 30 cycles: pulses at E, E+8, +12, +16, +20, +24.
    btn = 1'b1;
    cycles(13);
    check("repeat_gap", 32'(start_o[1]), 32'd0);
    cycles(1);
    check("repeat_first", 32'(start_o[1]), 32'd1);
    cycles(16);
    btn = 1'b0;
    cycles(12);
    check("repeat_count_b", 32'(cnt_o[15:8]), 32'd11);
    check("repeat_held_b", 32'(held_o[1]), 32'd0);
    check("repeat_count_a", 32'(cnt_o[7:0]), 32'd3);
    check("repeat_count_c", 32'(cnt_o[23:16]), 32'd4);

    // Reset on the edge that would accept the press, then release with
    // the button still high.
    btn = 1'b1;
    cycles(5);
    reset = 1'b1;
    cycles(1);
    check("rst_no_pulse", 32'(start_o[0]), 32'd0);
    check("rst_held", 32'(held_o[0]), 32'd0);
    check("rst_count", 32'(cnt_o[7:0]), 32'd0);
    reset = 1'b0;
    cycles(5);
    check("rst_no_early", 32'(start_o[0]), 32'd0);
    cycles(1);
    check("rst_late_pulse", 32'(start_o[0]), 32'd1);
    check("rst_late_count", 32'(cnt_o[7:0]), 32'd1);
    cycles(2);
    btn = 1'b0;
    cycles(10);

    // Wrap of press_count on the D=2 instance.
    reset = 1'b1;
    cycles(2);
    reset = 1'b0;
    cycles(2);
    for (int k = 1; k <= 257; k++) begin
      btn = 1'b1; cycles(3);
      btn = 1'b0; cycles(3);
      if (k == 255) check("wrap_255", 32'(cnt_o[23:16]), 32'd255);
      if (k == 256) check("wrap_0", 32'(cnt_o[23:16]), 32'd0);
      if (k == 257) check("wrap_1", 32'(cnt_o[23:16]), 32'd1);
    end
    check("wrap_short_press_a", 32'(cnt_o[7:0]), 32'd0);
    cycles(5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pulse_emitter.md
PULSE_EMITTER -- requirements
Module: pulse_emitter

Interface
REQ-001 Parameters, one per line: name, default, meaning:
- DEBOUNCE_CYCLES, 1000000: consecutive stable synchronized samples needed to accept a press or a release (legal range 2 to 2^24-1).
- REPEAT_EN, 0: 1 enables auto-repeat pulses while the button is held.
- REPEAT_DELAY, 50000000: cycles in PRESSED before the first repeat pulse (at least 2).
- REPEAT_PERIOD, 10000000: cycles between subsequent repeat pulses (at least 2; REPEAT_PERIOD <= REPEAT_DELAY).

REQ-002 Ports, one per line: name, direction, width, meaning:
- clk, input, 1: single clock; all state changes on its rising edge.
- reset, input, 1: synchronous, active-high.
- btn_raw, input, 1: asynchronous, bouncy pushbutton level.
- signal_start, output, 1: registered one-cycle start pulse; drives the start/stop toggler's start input.
- held, output, 1: registered debounced button level.
- press_count, output, 8: number of accepted signal_start pulses, modulo 256.

Function
REQ-003 btn_raw SHALL pass through a 2-flop synchronizer; btn_sync is the second flop, and no other logic SHALL sample btn_raw.
REQ-004 The FSM SHALL have four states: IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT.
REQ-005 IDLE: btn_sync=1 -> PRESS_WAIT, with the debounce counter loaded to 1; otherwise stay in IDLE.
REQ-006 PRESS_WAIT: btn_sync=0 -> IDLE, with no pulse.
- btn_sync=1 with counter=DEBOUNCE_CYCLES-1 -> PRESSED, and signal_start=1 for the next cycle.
- Otherwise counter+1.
REQ-007 Latency: if edge N is the first edge sampling btn_raw=1 and btn_raw then stays high, signal_start SHALL be high only in the cycle after edge N+1+DEBOUNCE_CYCLES, and held SHALL rise in that same cycle.
REQ-008 PRESSED: held=1; btn_sync=0 -> RELEASE_WAIT, with the debounce counter loaded to 1.
REQ-009 RELEASE_WAIT: held stays 1.
- btn_sync=1 -> PRESSED, with no pulse; this is a bounce and is ignored.
- btn_sync=0 with counter=DEBOUNCE_CYCLES-1 -> IDLE, and held=0 in the next cycle.
- Otherwise counter+1.
REQ-010 Auto-repeat, REPEAT_EN=1 only:
- The repeat counter SHALL clear on the PRESS_WAIT->PRESSED transition.
- It SHALL advance one per cycle spent in PRESSED and freeze in RELEASE_WAIT.
- One-cycle signal_start pulses SHALL follow the PRESSED edges at which the counter reaches REPEAT_DELAY, REPEAT_DELAY+REPEAT_PERIOD, REPEAT_DELAY+2*REPEAT_PERIOD, and so on.
REQ-011 With REPEAT_EN=0, exactly one signal_start pulse SHALL occur per accepted press, regardless of hold length.
REQ-012 press_count SHALL increment on every edge at which signal_start is set for the next cycle, wrapping 255 -> 0 without saturating or flagging.
REQ-013 signal_start SHALL never be high on two consecutive cycles.
REQ-014 Pulses shorter than DEBOUNCE_CYCLES synchronized samples SHALL produce no signal_start and leave held=0.
REQ-015 All counters SHALL be sized for their parameter maximum and SHALL never overflow within a state.

Reset
REQ-016 reset=1 at an edge SHALL, regardless of state or btn_raw, force the following:
- State=IDLE, synchronizer flops=0, all counters=0.
- signal_start=0, held=0, press_count=0.
REQ-017 reset SHALL take priority over every transition, including a pending pulse edge; no pulse SHALL appear in the cycle after a reset edge.
REQ-018 After reset deasserts with btn_raw already high, a press SHALL be accepted following the normal REQ-007 latency, counted from the first non-reset edge.

Verification (DEBOUNCE_CYCLES=4, REPEAT_DELAY=8, REPEAT_PERIOD=4 unless noted)
REQ-019 Clean press: btn_raw rises before edge 10 and is held 20 cycles with REPEAT_EN=0 -> signal_start high only after edge 15; held rises after edge 15; press_count=1.
REQ-020 Bounce: btn_raw sequence 1,1,0,1,1,0 per cycle, then 0 -> no signal_start, held stays 0, press_count stays 0; release bounce 0,1,0 inside PRESSED -> held stays 1 with no extra pulse.
REQ-021 Auto-repeat: REPEAT_EN=1 and btn_raw held 30 cycles -> pulses after PRESSED entry edge E and after E+8, E+12, E+16, E+20, E+24, up to the edge at which btn_sync=0 is sampled; no pulse after that; press_count equals the pulse count.
REQ-022 Wrap: 257 clean presses with DEBOUNCE_CYCLES=2 -> press_count reads 255, then 0, then 1.
REQ-023 Reset mid-press: reset asserted on the edge at which PRESS_WAIT would reach PRESSED -> no pulse, held=0, press_count unchanged at 0; releasing reset with btn_raw still high -> pulse per REQ-018.
REQ-024 Pulse width: in all scenarios above, signal_start is high exactly one cycle per pulse.
